ov7670_tx_emulator: RTL

- Synthesizable OV7670 camera-side transmitter that drives VSYNC, HREF, PCLK and 8-bit pixel data.
- Follows the same timing and RGB565 byte order that our capture/downsampler path consumes.
- Produces a deterministic test pattern so the capture, downsampler and DP RAM chain can be exercised on-board and in simulation without a physical sensor.
- Sits in place of the camera pins, feeding the capture block directly.

---
 rtl/ov7670_pkg.sv | 45 ++++
 rtl/ov7670_tx_emulator_if.sv | 12 +
 rtl/ov7670_pattern_gen.sv | 33 +++
 rtl/ov7670_tx_emulator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types for the OV7670 transmitter emulator.
// Contents: the frame-state enum, the pattern selector codes, the RGB565 pixel
// struct, the eight-entry colour-bar palette and a width helper.
package ov7670_pkg;

  localparam int unsigned COORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VFRONT
  } state_e;

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_RAMP    = 2'd2,
    PAT_CHECKER = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // White, yellow, cyan, green, magenta, red, blue, black at full scale.
  localparam rgb565_t BAR_PALETTE [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  // Bits needed to count 0..max_val-1, never less than one.
  function automatic int unsigned width_of(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ov7670_tx_emulator_if.sv
// Camera-pin bundle between the emulator and the capture block.
// Signals: PCLK pixel clock, VSYNC frame sync, HREF line valid, datos pixel byte.
// Modports: master drives the pins (emulator), slave samples them (capture).
interface ov7670_tx_emulator_if;
  logic       PCLK;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] datos;

  modport master (output PCLK, VSYNC, HREF, datos);
  modport slave  (input  PCLK, VSYNC, HREF, datos);
endinterface

// File: rtl/ov7670_pattern_gen.sv
// Combinational test-pattern source: pixel coordinate -> RGB565 colour.
// Ports: x, y pixel coordinates; sel pattern; color solid colour; rgb_c pixel.
module ov7670_pattern_gen
  import ov7670_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 160
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  pattern_e           sel,
  input  rgb565_t            color,
  output rgb565_t            rgb_c
);

  logic [2:0] bar_idx;
  logic       unused_y;

  // Eight equal-width bars across the active line.
  assign bar_idx  = 3'((32'(x) * 32'd8) / 32'(H_ACTIVE));
  assign unused_y = ^{y[COORD_W-1:4], y[2:0]};

  always_comb begin
    rgb_c = color;
    case (sel)
      PAT_SOLID:   rgb_c = color;
      PAT_BARS:    rgb_c = BAR_PALETTE[bar_idx];
      PAT_RAMP:    rgb_c = {x[4:0], x[5:0], x[4:0]};
      PAT_CHECKER: rgb_c = (x[3] ^ y[3]) ? rgb565_t'(16'hFFFF) : rgb565_t'(16'h0000);
      default:     rgb_c = color;
    endcase
  end

endmodule

// File: rtl/ov7670_tx_emulator.sv
// OV7670 camera-side transmitter emulator: drives PCLK/VSYNC/HREF/datos with a
// deterministic RGB565 test pattern (high byte first) for the capture chain.
// Ports: clk, rst (sync, active high); enable runs frames continuously;
// pattern_sel / solid_color latched at each frame start; bus camera pins
// (master); frame_done one-clk pulse at end of the front porch; busy while
// not idle. With macro TX_CHECKSUM_EN defined, checksum gives the 16-bit sum
// of all HREF-valid bytes of the last completed frame.
module ov7670_tx_emulator
  import ov7670_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 160,
  parameter int unsigned V_ACTIVE  = 120,
  parameter int unsigned H_BLANK   = 16,
  parameter int unsigned VSYNC_LEN = 3,
  parameter int unsigned V_BACK    = 2,
  parameter int unsigned V_FRONT   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [1:0]                  pattern_sel,
  input  logic [15:0]                 solid_color,
  ov7670_tx_emulator_if.master        bus,
  output logic                        frame_done,
  output logic                        busy
`ifdef TX_CHECKSUM_EN
  ,
  output logic [15:0]                 checksum
`endif
);

  localparam int unsigned LINE_LEN   = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned VSYNC_PER  = VSYNC_LEN * LINE_LEN;
  localparam int unsigned VBACK_PER  = V_BACK * LINE_LEN;
  localparam int unsigned VFRONT_PER = V_FRONT * LINE_LEN;
  localparam int unsigned ACT_PER    = 2 * H_ACTIVE;
  localparam int unsigned CNT_MAX    = max2(max2(VSYNC_PER, VBACK_PER),
                                            max2(VFRONT_PER, max2(ACT_PER, H_BLANK)));
  localparam int unsigned CNT_W      = width_of(CNT_MAX);
  localparam int unsigned X_W        = width_of(H_ACTIVE);
  localparam int unsigned Y_W        = width_of(V_ACTIVE);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               phase;
  pattern_e           sel_q;
  rgb565_t            color_q;
  logic               fall_c;
  logic [COORD_W-1:0] pix_x_c;
  logic [COORD_W-1:0] pix_y_c;
  rgb565_t            rgb_c;
  logic [7:0]         next_byte_c;
`ifdef TX_CHECKSUM_EN
  logic [15:0]        acc;
`endif

  assign fall_c = (state != ST_IDLE) && bus.PCLK;

  // Coordinate of the byte loaded on the next fall tick: after a low byte
  // the next pixel, at the end of a blank line the next row.
  always_comb begin
    pix_x_c = COORD_W'(x);
    pix_y_c = COORD_W'(y);
    if (state == ST_ACTIVE && phase) pix_x_c = COORD_W'(x) + COORD_W'(1);
    if (state == ST_HBLANK)          pix_y_c = COORD_W'(y) + COORD_W'(1);
  end

  ov7670_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_pattern (
    .x     (pix_x_c),
    .y     (pix_y_c),
    .sel   (sel_q),
    .color (color_q),
    .rgb_c (rgb_c)
  );

  assign next_byte_c = (state == ST_ACTIVE && !phase) ? {rgb_c.g[2:0], rgb_c.b}
                                                      : {rgb_c.r, rgb_c.g[5:3]};

  // Frame sequencer; everything except PCLK moves only on PCLK fall ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      x          <= '0;
      y          <= '0;
      phase      <= 1'b0;
      sel_q      <= PAT_SOLID;
      color_q    <= '0;
      bus.PCLK   <= 1'b0;
      bus.VSYNC  <= 1'b0;
      bus.HREF   <= 1'b0;
      bus.datos  <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
`ifdef TX_CHECKSUM_EN
      acc        <= '0;
      checksum   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      bus.PCLK   <= (state != ST_IDLE) ? ~bus.PCLK : 1'b0;
      if (state == ST_IDLE) begin
        if (enable) begin
          state     <= ST_VSYNC;
          cnt       <= '0;
          busy      <= 1'b1;
          bus.VSYNC <= 1'b1;
          sel_q     <= pattern_e'(pattern_sel);
          color_q   <= rgb565_t'(solid_color);
`ifdef TX_CHECKSUM_EN
          acc       <= '0;
`endif
        end
      end else if (fall_c) begin
        cnt <= cnt + CNT_W'(1);
        case (state)
          ST_VSYNC: begin
            if (cnt == CNT_W'(VSYNC_PER - 1)) begin
              state     <= ST_VBACK;
              cnt       <= '0;
              bus.VSYNC <= 1'b0;
            end
          end
          ST_VBACK: begin
            if (cnt == CNT_W'(VBACK_PER - 1)) begin
              state     <= ST_ACTIVE;
              cnt       <= '0;
              phase     <= 1'b0;
              bus.HREF  <= 1'b1;
              bus.datos <= next_byte_c;
`ifdef TX_CHECKSUM_EN
              acc       <= acc + 16'(next_byte_c);
`endif
            end
          end
          ST_ACTIVE: begin
            if (cnt == CNT_W'(ACT_PER - 1)) begin
              state     <= ST_HBLANK;
              cnt       <= '0;
              x         <= '0;
              phase     <= 1'b0;
              bus.HREF  <= 1'b0;
              bus.datos <= '0;
            end else begin
              phase     <= ~phase;
              if (phase) x <= x + X_W'(1);
              bus.datos <= next_byte_c;
`ifdef TX_CHECKSUM_EN
              acc       <= acc + 16'(next_byte_c);
`endif
            end
          end
          ST_HBLANK: begin
            if (cnt == CNT_W'(H_BLANK - 1)) begin
              cnt <= '0;
              if (y == Y_W'(V_ACTIVE - 1)) begin
                state <= ST_VFRONT;
                y     <= '0;
              end else begin
                state     <= ST_ACTIVE;
                y         <= y + Y_W'(1);
                phase     <= 1'b0;
                bus.HREF  <= 1'b1;
                bus.datos <= next_byte_c;
`ifdef TX_CHECKSUM_EN
                acc       <= acc + 16'(next_byte_c);
`endif
              end
            end
          end
          ST_VFRONT: begin
            if (cnt == CNT_W'(VFRONT_PER - 1)) begin
              cnt        <= '0;
              frame_done <= 1'b1;
`ifdef TX_CHECKSUM_EN
              checksum   <= acc;
`endif
              if (enable) begin
                state     <= ST_VSYNC;
                bus.VSYNC <= 1'b1;
                sel_q     <= pattern_e'(pattern_sel);
                color_q   <= rgb565_t'(solid_color);
`ifdef TX_CHECKSUM_EN
                acc       <= '0;
`endif
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
